// File: rtl/rr_arb_mux_pkg.sv
// Shared helpers for the round-robin arbitrating stream mux.
//   sel_width(n) : width of an index able to name any of n inputs, at least 1.
package rr_arb_mux_pkg;

  function automatic int unsigned sel_width(input int unsigned n);
    if (n <= 32'd1) return 32'd1;
    return int'($clog2(n));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector, one bit per requester
//   ptr     : index of the requester with highest priority this cycle
//   gnt     : one-hot grant (all zero when no request)
//   gnt_idx : binary index of the granted requester (0 when none)
//   any     : at least one request is present
module rr_arbiter
  import rr_arb_mux_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned SELW = sel_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);

  // Requests laid out twice so the wrap-around search from ptr is a plain
  // low-to-high scan starting at bit ptr of the doubled vector.
  logic [2*N-1:0] req2;

  assign req2 = {req, req};

  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    for (int unsigned i = 0; i < 2 * N; i++) begin
      if (!any && req2[i] && (i >= 32'(ptr))) begin
        any     = 1'b1;
        gnt_idx = (i >= N) ? SELW'(i - N) : SELW'(i);
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int unsigned k = 0; k < N; k++) begin
      gnt[k] = any && (gnt_idx == SELW'(k));
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-input valid/ready stream mux with round-robin arbitration and a
// registered output stage.
//   clk, reset : clock and synchronous active-high reset
//   in_val     : per-input valid
//   in_rdy     : per-input ready, at most one bit high (the granted input)
//   in_msg     : packed messages, input i at [i*p_nbits +: p_nbits]
//   out_val    : output register holds a message
//   out_rdy    : downstream accepts the held message
//   out_msg    : registered message
//   out_sel    : index of the input that supplied out_msg
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int unsigned p_nbits   = 32,
  parameter int unsigned p_ninputs = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [p_ninputs-1:0]              in_val,
  output logic [p_ninputs-1:0]              in_rdy,
  input  logic [p_ninputs*p_nbits-1:0]      in_msg,
  output logic                              out_val,
  input  logic                              out_rdy,
  output logic [p_nbits-1:0]                out_msg,
  output logic [sel_width(p_ninputs)-1:0]   out_sel
);

  localparam int unsigned SELW = sel_width(p_ninputs);
  localparam int unsigned MSGW = p_ninputs * p_nbits;
  localparam int unsigned BASW = (MSGW > 1) ? int'($clog2(MSGW)) : 1;

  logic [SELW-1:0]      ptr;
  logic [SELW-1:0]      ptr_next;
  logic [SELW-1:0]      gnt_idx;
  logic [p_ninputs-1:0] gnt;
  logic                 any;
  logic                 can_load;
  logic                 load;
  logic [BASW-1:0]      base;

  rr_arbiter #(
    .N    (p_ninputs),
    .SELW (SELW)
  ) u_arb (
    .req     (in_val),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // The register may take a new message when empty or when it drains now.
  assign can_load = !out_val || out_rdy;
  assign load     = can_load && any && !reset;
  assign in_rdy   = load ? gnt : '0;

  // Priority moves to the input after the winner, wrapping at the top.
  assign ptr_next = (gnt_idx == SELW'(p_ninputs - 1)) ? '0 : gnt_idx + 1'b1;

  assign base = BASW'(32'(gnt_idx) * p_nbits);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_val <= 1'b0;
      out_msg <= '0;
      out_sel <= '0;
      ptr     <= '0;
    end else if (load) begin
      out_val <= 1'b1;
      out_msg <= in_msg[base +: p_nbits];
      out_sel <= gnt_idx;
      ptr     <= ptr_next;
    end else if (out_val && out_rdy) begin
      out_val <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
module tb_rr_arb_mux;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        out_rdy;
  logic [3:0]  in_val;
  logic [31:0] msg_in [4];

  logic [0:0]  rdy1;  logic val1;  logic [0:0]  msg1;  logic [0:0] sel1;
  logic [2:0]  rdy3;  logic val3;  logic [4:0]  msg3;  logic [1:0] sel3;
  logic [3:0]  rdy4;  logic val4;  logic [31:0] msg4;  logic [1:0] sel4;

  rr_arb_mux #(.p_nbits(1), .p_ninputs(1)) dut1 (
    .clk(clk), .reset(reset), .in_val(in_val[0:0]), .in_rdy(rdy1),
    .in_msg(msg_in[0][0:0]), .out_val(val1), .out_rdy(out_rdy),
    .out_msg(msg1), .out_sel(sel1));

  rr_arb_mux #(.p_nbits(5), .p_ninputs(3)) dut3 (
    .clk(clk), .reset(reset), .in_val(in_val[2:0]), .in_rdy(rdy3),
    .in_msg({msg_in[2][4:0], msg_in[1][4:0], msg_in[0][4:0]}),
    .out_val(val3), .out_rdy(out_rdy), .out_msg(msg3), .out_sel(sel3));

  rr_arb_mux #(.p_nbits(32), .p_ninputs(4)) dut4 (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(rdy4),
    .in_msg({msg_in[3], msg_in[2], msg_in[1], msg_in[0]}),
    .out_val(val4), .out_rdy(out_rdy), .out_msg(msg4), .out_sel(sel4));

  // Active suite: 0 -> (1,1), 1 -> (5,3), 2 -> (32,4)
  int unsigned suite;
  int          n;
  logic [31:0] wmask;
  logic [3:0]  nmask;

  logic [3:0]  g_in_rdy;
  logic        g_out_val;
  logic [31:0] g_out_msg;
  logic [1:0]  g_out_sel;

  always_comb begin
    case (suite)
      0: begin
        g_in_rdy = {3'b0, rdy1}; g_out_val = val1;
        g_out_msg = {31'b0, msg1}; g_out_sel = {1'b0, sel1};
      end
      1: begin
        g_in_rdy = {1'b0, rdy3}; g_out_val = val3;
        g_out_msg = {27'b0, msg3}; g_out_sel = sel3;
      end
      default: begin
        g_in_rdy = rdy4; g_out_val = val4;
        g_out_msg = msg4; g_out_sel = sel4;
      end
    endcase
  end

  typedef struct packed {
    logic [31:0] msg;
    logic [1:0]  sel;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   running = 1'b0;
  bit   m_val;
  int   m_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (suite %0d, t=%0t): got %h expected %h", name, suite, $time, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int p, input int nn);
    for (int off = 0; off < nn; off++) begin
      int k;
      k = (p + off) % nn;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  // Monitor: output side of the scoreboard.
  always @(negedge clk) begin
    if (running && !reset) begin
      chk("out_val", 32'(g_out_val), 32'(q.size() != 0));
      if (g_out_val && out_rdy && q.size() != 0) begin
        mon_e = q.pop_front();
        chk("out_msg", g_out_msg, mon_e.msg);
        chk("out_sel", 32'(g_out_sel), 32'(mon_e.sel));
      end
    end
  end

  // One clock cycle of stimulus; entered and left at posedge+1.
  task automatic cyc(input logic [3:0] v, input logic ordy, input logic rst);
    int         g;
    logic       xfer;
    logic [3:0] exp_rdy;
    exp_t       e;
    in_val  = v & nmask;
    out_rdy = ordy;
    reset   = rst;
    #6;
    g       = rr_pick(in_val, m_ptr, n);
    xfer    = !rst && (!m_val || ordy) && (g >= 0);
    exp_rdy = '0;
    if (xfer) exp_rdy[g] = 1'b1;
    chk("in_rdy", 32'(g_in_rdy), 32'(exp_rdy));
    @(posedge clk);
    #1;
    if (rst) begin
      m_val = 1'b0;
      m_ptr = 0;
      q.delete();
    end else if (xfer) begin
      e.msg = msg_in[g] & wmask;
      e.sel = 2'(g);
      q.push_back(e);
      m_val = 1'b1;
      m_ptr = (g + 1) % n;
    end else if (m_val && ordy) begin
      m_val = 1'b0;
    end
  endtask

  task automatic set_msgs(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] d);
    msg_in[0] = a; msg_in[1] = b; msg_in[2] = c; msg_in[3] = d;
  endtask

  task automatic run_suite(input int unsigned s);
    suite = s;
    n     = (s == 0) ? 1 : (s == 1) ? 3 : 4;
    wmask = (s == 0) ? 32'h1 : (s == 1) ? 32'h1f : 32'hffff_ffff;
    nmask = 4'((1 << n) - 1);
    set_msgs(32'hA0A0_0001, 32'hB1B1_1111, 32'hDEAD_BEEF, 32'hC3C3_3333);

    // Reset held two cycles with every input valid
    cyc(4'hF, 1'b1, 1'b1);
    cyc(4'hF, 1'b1, 1'b1);
    chk("rst_out_val", 32'(g_out_val), 32'd0);
    chk("rst_out_msg", g_out_msg, 32'd0);
    chk("rst_out_sel", 32'(g_out_sel), 32'd0);

    // Fairness from reset: grants 0,1,..,n-1,0,..
    for (int i = 0; i < 2 * n; i++) begin
      cyc(4'hF, 1'b1, 1'b0);
      chk("fair_val", 32'(g_out_val), 32'd1);
      chk("fair_sel", 32'(g_out_sel), 32'(i % n));
    end
    cyc(4'h0, 1'b1, 1'b0);

    if (s == 2) begin
      // Single source: input 2 only
      cyc(4'b0100, 1'b1, 1'b0);
      chk("single_val", 32'(g_out_val), 32'd1);
      chk("single_msg", g_out_msg, 32'hDEAD_BEEF);
      chk("single_sel", 32'(g_out_sel), 32'd2);
      // Wrap and skip: ptr=3, inputs 3 and 0 valid
      cyc(4'b1001, 1'b1, 1'b0);
      chk("wrap_sel3", 32'(g_out_sel), 32'd3);
      cyc(4'b1001, 1'b1, 1'b0);
      chk("wrap_sel0", 32'(g_out_sel), 32'd0);
      cyc(4'b0010, 1'b1, 1'b0);
      chk("skip_sel1", 32'(g_out_sel), 32'd1);
      // Backpressure while input 1's message is held
      for (int i = 0; i < 3; i++) begin
        cyc(4'hF, 1'b0, 1'b0);
        chk("stall_rdy", 32'(g_in_rdy), 32'd0);
        chk("stall_sel", 32'(g_out_sel), 32'd1);
        chk("stall_msg", g_out_msg, 32'hB1B1_1111);
      end
      cyc(4'hF, 1'b1, 1'b0);
      chk("release_sel", 32'(g_out_sel), 32'd2);
      // Reset in the middle of a stall discards the message and ptr
      cyc(4'hF, 1'b0, 1'b0);
      chk("prestall_val", 32'(g_out_val), 32'd1);
      cyc(4'hF, 1'b0, 1'b1);
      chk("midrst_val", 32'(g_out_val), 32'd0);
      cyc(4'hF, 1'b1, 1'b0);
      chk("postrst_sel", 32'(g_out_sel), 32'd0);
      cyc(4'h0, 1'b1, 1'b0);
    end

    // Random traffic against the scoreboard
    for (int i = 0; i < 200; i++) begin
      for (int k = 0; k < 4; k++) msg_in[k] = $urandom;
      cyc(4'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
    end

    cyc(4'h0, 1'b1, 1'b0);
    cyc(4'h0, 1'b1, 1'b0);
    chk("drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    suite   = 2;
    n       = 4;
    wmask   = '1;
    nmask   = '1;
    m_val   = 1'b0;
    m_ptr   = 0;
    reset   = 1'b1;
    out_rdy = 1'b0;
    in_val  = '0;
    set_msgs('0, '0, '0, '0);
    @(posedge clk);
    #1;
    running = 1'b1;
    run_suite(0);
    run_suite(1);
    run_suite(2);
    running = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
